// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, sequencer state enum and column-x helper
package game_pkg;
  localparam int RES_W    = 160;
  localparam int RES_H    = 120;
  localparam int COL_W    = 35;
  localparam int BORDER_W = 4;
  localparam int TILE_H   = RES_H / 6;
  localparam int NUM_COLS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT_TICK,
    S_SHIFT,
    S_WAIT_DONE,
    S_ADVANCE
  } state_t;

  // Left pixel of a column: 4/43/82/121, kept in 8-bit unsigned arithmetic.
  function automatic logic [7:0] column_x(input logic [1:0] col);
    logic [7:0] c8;
    c8 = {6'd0, col};
    return 8'(BORDER_W) + c8 * 8'(COL_W + BORDER_W);
  endfunction
endpackage

// File: rtl/tile_sequencer_if.sv
// rtl/tile_sequencer_if.sv - control, key and renderer signals of the tile sequencer
interface tile_sequencer_if;
  logic       start;
  logic       pause;
  logic       key_valid;
  logic [1:0] key_col;
  logic       finished;
  logic       tileShiftEnable;
  logic [7:0] xStart;
  logic [6:0] yStart;
  logic [1:0] column;
  logic       hit;
  logic       miss;
  logic       timeout_err;
  logic       busy;

  modport master (
    input  start, pause, key_valid, key_col, finished,
    output tileShiftEnable, xStart, yStart, column, hit, miss, timeout_err, busy
  );

  modport slave (
    output start, pause, key_valid, key_col, finished,
    input  tileShiftEnable, xStart, yStart, column, hit, miss, timeout_err, busy
  );
endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, taps 8,6,5,4, loads seed on reset
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (enable) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end
endmodule

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - paces tile scroll steps, drives the renderer and judges key hits
module tile_sequencer
  import game_pkg::*;
#(
  parameter int         STEP_DIV  = 833333,
  parameter int         TIMEOUT   = 1024,
  parameter int         HIT_LO    = 80,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic               CLOCK_50,
  input logic               resetn,
  tile_sequencer_if.master  bus
);
  localparam int             TW        = $clog2(STEP_DIV + 1);
  localparam int             WW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0]  WAIT_IGN  = WW'(2);
  localparam logic [6:0]     ROW_LAST  = 7'(RES_H - 1);
  localparam logic [6:0]     ROW_HIT   = 7'(HIT_LO);

  state_t        state;
  logic [TW-1:0] tick;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    lfsr;
  logic [5:0]    lfsr_unused;
  logic          key_pend;
  logic [1:0]    key_lat;
  logic          key_now;
  logic [1:0]    key_c;
  logic          key_good;
  logic [1:0]    pick;

  lfsr8 u_lfsr (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .enable (state == S_SPAWN),
    .seed   (LFSR_SEED),
    .q      (lfsr)
  );

  assign lfsr_unused = lfsr[7:2];

  // A key arriving this cycle overrides the latched one, so WAIT_TICK judges it at once.
  always_comb begin
    key_now  = bus.key_valid | key_pend;
    key_c    = bus.key_valid ? bus.key_col : key_lat;
    key_good = key_now && (key_c == bus.column) && (bus.yStart >= ROW_HIT);
    pick     = (lfsr[1:0] == bus.column) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state               <= S_IDLE;
      tick                <= '0;
      wait_cnt            <= '0;
      key_pend            <= 1'b0;
      key_lat             <= 2'd0;
      bus.tileShiftEnable <= 1'b0;
      bus.xStart          <= 8'd0;
      bus.yStart          <= 7'd0;
      bus.column          <= 2'd0;
      bus.hit             <= 1'b0;
      bus.miss            <= 1'b0;
      bus.timeout_err     <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      bus.hit         <= 1'b0;
      bus.miss        <= 1'b0;
      bus.timeout_err <= 1'b0;
      if (bus.key_valid && state != S_IDLE) begin
        key_pend <= 1'b1;
        key_lat  <= bus.key_col;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            state    <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          bus.column <= pick;
          bus.xStart <= column_x(pick);
          bus.yStart <= 7'd0;
          tick       <= '0;
          key_pend   <= 1'b0;
          state      <= S_WAIT_TICK;
        end
        S_WAIT_TICK: begin
          if (key_now) key_pend <= 1'b0;
          if (key_good) begin
            bus.hit <= 1'b1;
            state   <= S_SPAWN;
          end else begin
            if (key_now) bus.miss <= 1'b1;
            if (!bus.pause) begin
              if (tick == TICK_LAST) begin
                tick  <= '0;
                state <= S_SHIFT;
              end else begin
                tick <= tick + 1'b1;
              end
            end
          end
        end
        S_SHIFT: begin
          bus.tileShiftEnable <= 1'b1;
          wait_cnt            <= '0;
          state               <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // finished may linger from the previous step, so the first two cycles ignore it
          if (wait_cnt >= WAIT_IGN && bus.finished) begin
            bus.tileShiftEnable <= 1'b0;
            state               <= S_ADVANCE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.timeout_err     <= 1'b1;
            bus.tileShiftEnable <= 1'b0;
            state               <= S_ADVANCE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ADVANCE: begin
          if (bus.yStart == ROW_LAST) begin
            if (key_good) bus.hit <= 1'b1;
            else          bus.miss <= 1'b1;
            state <= S_SPAWN;
          end else begin
            bus.yStart <= bus.yStart + 7'd1;
            state      <= S_WAIT_TICK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
